// File: rtl/mhd_pkg.sv
// Shared types and helpers for the sampled Hamming-distance miter checkers.
//   state_t   : controller states (IDLE, RUN, DRAIN, DONE)
//   hd_width  : bits needed to hold a Hamming distance of a w-bit vector
//   sat_inc   : increment that sticks at the all-ones value of a w-bit field
package mhd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int hd_width(input int w);
    return $clog2(w + 1);
  endfunction

  // Operates on a 64-bit carrier so one helper serves any counter width;
  // callers cast in and out of their own field width.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] lim;
    lim = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= lim) ? lim : v + 64'd1;
  endfunction

endpackage

// File: rtl/mhd_popcount_stage.sv
// Two-stage registered XOR-popcount-compare with valid and index tags.
//   S1 registers diff = a ^ b, the index tag and the valid bit.
//   S2 registers hd = popcount(diff), viol = (hd > thr), index and valid.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   kill              : drop the S1 sample instead of advancing it into S2
//   in_valid, a, b    : input pair and its valid bit
//   in_idx            : tag carried alongside the pair
//   thr               : violation threshold (strictly greater violates)
//   s1_valid          : S1 holds a sample
//   viol_nxt          : the sample in S1 will register as a violation in S2
//   out_valid/hd/viol/idx : S2 contents
module mhd_popcount_stage
  import mhd_pkg::*;
#(
  parameter int WIDTH = 18,
  parameter int IDXW  = 20,
  localparam int HDW  = hd_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             kill,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [IDXW-1:0]  in_idx,
  input  logic [HDW-1:0]   thr,
  output logic             s1_valid,
  output logic             viol_nxt,
  output logic             out_valid,
  output logic [HDW-1:0]   out_hd,
  output logic             out_viol,
  output logic [IDXW-1:0]  out_idx
);

  logic [WIDTH-1:0] s1_diff;
  logic [IDXW-1:0]  s1_idx;
  logic [HDW-1:0]   hd_nxt;

  always_comb begin
    hd_nxt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      hd_nxt = hd_nxt + HDW'(s1_diff[i]);
    end
  end

  assign viol_nxt = s1_valid && (hd_nxt > thr);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_diff   <= '0;
      s1_idx    <= '0;
      out_valid <= 1'b0;
      out_hd    <= '0;
      out_viol  <= 1'b0;
      out_idx   <= '0;
    end else begin
      s1_valid  <= in_valid;
      s1_diff   <= a ^ b;
      s1_idx    <= in_idx;
      out_valid <= s1_valid && !kill;
      out_hd    <= hd_nxt;
      out_viol  <= viol_nxt && !kill;
      out_idx   <= s1_idx;
    end
  end

endmodule

// File: rtl/mhd_sample_checker.sv
// Sampled Hamming-distance checker between an exact and an approximate
// circuit. Streams N (a, b) pairs through a 2-stage popcount pipeline and
// reports violation count, maximum distance and first violating index.
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   start                      : run request, honoured only in IDLE
//   num_samples, mhd_thr,
//   stop_on_viol               : run configuration, latched on start
//   in_valid, in_ready, a, b   : pair handshake
//   busy, done                 : run status (done is a one-cycle pulse)
//   viol_cnt, max_hd,
//   first_viol_idx, viol_seen  : run results, held until the next start
//
// state | meaning
// IDLE  | waiting for start; results from the last run are held
// RUN   | accepting pairs until N accepted or a stop-on-violation hit
// DRAIN | letting the pipeline empty (S1 discarded after a stop hit)
// DONE  | one-cycle done pulse, then back to IDLE
module mhd_sample_checker
  import mhd_pkg::*;
#(
  parameter int WIDTH = 18,
  parameter int CNTW  = 20,
  localparam int HDW  = hd_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNTW-1:0]  num_samples,
  input  logic [HDW-1:0]   mhd_thr,
  input  logic             stop_on_viol,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [CNTW-1:0]  viol_cnt,
  output logic [HDW-1:0]   max_hd,
  output logic [CNTW-1:0]  first_viol_idx,
  output logic             viol_seen
);

  state_t          state, state_nxt;
  logic [CNTW-1:0] n_lat;
  logic [CNTW-1:0] acc_cnt;
  logic [HDW-1:0]  thr_lat;
  logic            stop_lat;
  logic            stop_hit;

  logic            start_ok;
  logic            accept;
  logic            last_acc;
  logic            stop_trig;

  logic            s1_valid;
  logic            viol_nxt;
  logic            s2_valid;
  logic [HDW-1:0]  s2_hd;
  logic            s2_viol;
  logic [CNTW-1:0] s2_idx;

  assign start_ok  = (state == IDLE) && start;
  assign in_ready  = (state == RUN) && (acc_cnt < n_lat) && !stop_hit;
  assign accept    = in_valid && in_ready;
  assign last_acc  = accept && ((acc_cnt + CNTW'(1)) == n_lat);
  // The violation is detected as it enters S2, so the pair accepted in the
  // same cycle still lands in S1 and is dropped by kill on the next edge.
  assign stop_trig = (state == RUN) && stop_lat && viol_nxt;
  assign busy      = (state == RUN) || (state == DRAIN);
  assign done      = (state == DONE);

  mhd_popcount_stage #(
    .WIDTH (WIDTH),
    .IDXW  (CNTW)
  ) u_stage (
    .clk       (clk),
    .rst_n     (rst_n),
    .kill      (stop_hit),
    .in_valid  (accept),
    .a         (a),
    .b         (b),
    .in_idx    (acc_cnt),
    .thr       (thr_lat),
    .s1_valid  (s1_valid),
    .viol_nxt  (viol_nxt),
    .out_valid (s2_valid),
    .out_hd    (s2_hd),
    .out_viol  (s2_viol),
    .out_idx   (s2_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // DRAIN leaves on the edge where the last S2 sample updates the results,
  // so DONE already sees final values. With stop_hit, S1 never reaches S2.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (num_samples == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_acc || stop_trig) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (!s1_valid || stop_hit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      n_lat    <= '0;
      thr_lat  <= '0;
      stop_lat <= 1'b0;
      acc_cnt  <= '0;
      stop_hit <= 1'b0;
    end else if (start_ok) begin
      n_lat    <= num_samples;
      thr_lat  <= mhd_thr;
      stop_lat <= stop_on_viol;
      acc_cnt  <= '0;
      stop_hit <= 1'b0;
    end else begin
      if (accept) begin
        acc_cnt <= acc_cnt + CNTW'(1);
      end
      if (stop_trig) begin
        stop_hit <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      viol_cnt       <= '0;
      max_hd         <= '0;
      first_viol_idx <= '0;
      viol_seen      <= 1'b0;
    end else if (start_ok) begin
      viol_cnt       <= '0;
      max_hd         <= '0;
      first_viol_idx <= '0;
      viol_seen      <= 1'b0;
    end else if (s2_valid) begin
      if (s2_hd > max_hd) begin
        max_hd <= s2_hd;
      end
      if (s2_viol) begin
        viol_cnt <= CNTW'(sat_inc(64'(viol_cnt), CNTW));
        if (!viol_seen) begin
          first_viol_idx <= s2_idx;
          viol_seen      <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mhd_sample_checker.sv
module tb_mhd_sample_checker;

  localparam int WIDTH = 18;
  localparam int CNTW  = 20;
  localparam int HDW   = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [CNTW-1:0]  num_samples;
  logic [HDW-1:0]   mhd_thr;
  logic             stop_on_viol;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [CNTW-1:0]  viol_cnt;
  logic [HDW-1:0]   max_hd;
  logic [CNTW-1:0]  first_viol_idx;
  logic             viol_seen;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  typedef struct {
    int vcnt;
    int mhd;
    int fidx;
    int seen;
    int nacc;
    int lat;
  } res_t;

  res_t             exp_q[$];
  logic [WIDTH-1:0] pa[$];
  logic [WIDTH-1:0] pb[$];

  mhd_sample_checker #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .num_samples    (num_samples),
    .mhd_thr        (mhd_thr),
    .stop_on_viol   (stop_on_viol),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .a              (a),
    .b              (b),
    .busy           (busy),
    .done           (done),
    .viol_cnt       (viol_cnt),
    .max_hd         (max_hd),
    .first_viol_idx (first_viol_idx),
    .viol_seen      (viol_seen)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
  end

  task automatic add_pair(input int hd);
    logic [WIDTH-1:0] av;
    logic [WIDTH-1:0] m;
    logic [WIDTH:0]   full;
    int r;
    av = WIDTH'($urandom);
    full = '0;
    full[0] = 1'b1;
    full = full << hd;
    full = full - {{WIDTH{1'b0}}, 1'b1};
    m = full[WIDTH-1:0];
    r = $urandom_range(0, WIDTH - 1);
    if (r != 0) m = (m << r) | (m >> (WIDTH - r));
    pa.push_back(av);
    pb.push_back(av ^ m);
  endtask

  task automatic do_start(input int n, input int thr, input bit stop);
    in_valid     = 1'b0;
    num_samples  = CNTW'(n);
    mhd_thr      = HDW'(thr);
    stop_on_viol = stop;
    start        = 1'b1;
    @(posedge clk); #1;
    start        = 1'b0;
  endtask

  task automatic run_case(input string name, input int n, input int thr, input bit stop,
                          input bit gaps, input int poke);
    res_t e;
    int   lim, hd, k, cyc, last_edge, d0;
    bit   stopped;
    e = '{vcnt: 0, mhd: 0, fidx: 0, seen: 0, nacc: 0, lat: 2};
    lim = (n < pa.size()) ? n : pa.size();
    e.nacc = lim;
    stopped = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if (!stopped) begin
        hd = $countones(pa[i] ^ pb[i]);
        if (hd > e.mhd) e.mhd = hd;
        if (hd > thr) begin
          e.vcnt++;
          if (e.seen == 0) begin
            e.seen = 1;
            e.fidx = i;
          end
          if (stop) begin
            stopped = 1'b1;
            e.nacc = (i + 2 < lim) ? i + 2 : lim;
            if (i < lim - 1) e.lat = 1;
          end
        end
      end
    end
    exp_q.push_back(e);

    d0 = done_cnt;
    do_start(n, thr, stop);
    k = 0;
    cyc = 0;
    last_edge = 0;
    while (done !== 1'b1 && cyc < 300) begin
      if (poke >= 0 && cyc == poke) begin
        start   = 1'b1;
        mhd_thr = '0;
      end else begin
        start   = 1'b0;
        mhd_thr = HDW'(thr);
      end
      if (k < pa.size() && (!gaps || $urandom_range(0, 2) == 0)) begin
        in_valid = 1'b1;
        a = pa[k];
        b = pb[k];
      end else begin
        in_valid = 1'b0;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
      end
      if (in_valid && in_ready) begin
        k++;
        last_edge = cyc + 1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    start    = 1'b0;

    e = exp_q.pop_front();
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL %s done_timeout: got done=%b after %0d cycles, want 1", name, done, cyc);
    end
    total++;
    if (k !== e.nacc) begin
      bad++;
      $display("FAIL %s accepts: got %0d want %0d", name, k, e.nacc);
    end
    total++;
    if (viol_cnt !== CNTW'(e.vcnt)) begin
      bad++;
      $display("FAIL %s viol_cnt: got %0d want %0d", name, viol_cnt, e.vcnt);
    end
    total++;
    if (max_hd !== HDW'(e.mhd)) begin
      bad++;
      $display("FAIL %s max_hd: got %0d want %0d", name, max_hd, e.mhd);
    end
    total++;
    if (viol_seen !== e.seen[0]) begin
      bad++;
      $display("FAIL %s viol_seen: got %b want %0d", name, viol_seen, e.seen);
    end
    total++;
    if (first_viol_idx !== CNTW'(e.fidx)) begin
      bad++;
      $display("FAIL %s first_viol_idx: got %0d want %0d", name, first_viol_idx, e.fidx);
    end
    total++;
    if (cyc - last_edge !== e.lat) begin
      bad++;
      $display("FAIL %s drain_latency: got %0d want %0d", name, cyc - last_edge, e.lat);
    end
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0 || done_cnt !== d0 + 1) begin
      bad++;
      $display("FAIL %s done_pulse: got done=%b pulses=%0d want done=0 pulses=1",
               name, done, done_cnt - d0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    num_samples = '0;
    mhd_thr = '0;
    stop_on_viol = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({in_ready, busy, done, viol_seen} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags: got %b want 0000", {in_ready, busy, done, viol_seen});
    end
    total++;
    if (viol_cnt !== '0 || max_hd !== '0 || first_viol_idx !== '0) begin
      bad++;
      $display("FAIL reset_results: got cnt=%0d max=%0d idx=%0d want 0", viol_cnt, max_hd,
               first_viol_idx);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_exact_match();
    pa.delete(); pb.delete();
    for (int i = 0; i < 8; i++) add_pair(0);
    run_case("exact_match", 8, 2, 1'b0, 1'b0, -1);
  endtask

  task automatic test_threshold_boundary();
    pa.delete(); pb.delete();
    add_pair(2); add_pair(3); add_pair(18); add_pair(0);
    run_case("thr_boundary", 4, 2, 1'b0, 1'b0, -1);
  endtask

  task automatic test_stop_on_viol();
    int hds[10] = '{1, 0, 2, 5, 18, 1, 1, 1, 1, 1};
    pa.delete(); pb.delete();
    foreach (hds[i]) add_pair(hds[i]);
    run_case("stop_on_viol", 10, 2, 1'b1, 1'b0, -1);
  endtask

  task automatic test_zero();
    int d0;
    d0 = done_cnt;
    do_start(0, 3, 1'b0);
    total++;
    if (done !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL zero_run_status: got done=%b ready=%b busy=%b want 1 0 0", done, in_ready, busy);
    end
    total++;
    if (viol_cnt !== '0 || max_hd !== '0 || viol_seen !== 1'b0 || first_viol_idx !== '0) begin
      bad++;
      $display("FAIL zero_run_results: got cnt=%0d max=%0d seen=%b idx=%0d want 0", viol_cnt,
               max_hd, viol_seen, first_viol_idx);
    end
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0 || in_ready !== 1'b0 || done_cnt !== d0 + 1) begin
      bad++;
      $display("FAIL zero_run_pulse: got done=%b ready=%b pulses=%0d want 0 0 1", done, in_ready,
               done_cnt - d0);
    end
  endtask

  task automatic test_backpressure();
    pa.delete(); pb.delete();
    for (int i = 0; i < 7; i++) add_pair($urandom_range(0, 6));
    run_case("backpressure", 5, 3, 1'b0, 1'b1, -1);
  endtask

  task automatic test_reset_mid_run();
    int d0;
    pa.delete(); pb.delete();
    for (int i = 0; i < 6; i++) add_pair(9);
    do_start(10, 2, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a = pa[i];
      b = pb[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    d0 = done_cnt;
    @(posedge clk); #1;
    total++;
    if ({in_ready, busy, done, viol_seen} !== 4'b0000) begin
      bad++;
      $display("FAIL midrst_flags: got %b want 0000", {in_ready, busy, done, viol_seen});
    end
    total++;
    if (viol_cnt !== '0 || max_hd !== '0 || first_viol_idx !== '0) begin
      bad++;
      $display("FAIL midrst_results: got cnt=%0d max=%0d idx=%0d want 0", viol_cnt, max_hd,
               first_viol_idx);
    end
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (done_cnt !== d0) begin
      bad++;
      $display("FAIL midrst_no_done: got %0d pulses want 0", done_cnt - d0);
    end
    pa.delete(); pb.delete();
    add_pair(4); add_pair(1); add_pair(7);
    run_case("after_reset", 3, 3, 1'b0, 1'b0, -1);
  endtask

  task automatic test_start_while_busy();
    pa.delete(); pb.delete();
    add_pair(3); add_pair(6); add_pair(1); add_pair(7);
    run_case("start_busy", 4, 5, 1'b0, 1'b0, 2);
  endtask

  task automatic test_back_to_back();
    pa.delete(); pb.delete();
    for (int i = 0; i < 6; i++) add_pair($urandom_range(0, 18));
    run_case("b2b_first", 6, 9, 1'b0, 1'b0, -1);
    run_case("b2b_second", 6, 4, 1'b0, 1'b0, -1);
  endtask

  initial begin
    test_reset();
    test_exact_match();
    test_threshold_boundary();
    test_stop_on_viol();
    test_zero();
    test_backpressure();
    test_reset_mid_run();
    test_start_while_busy();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
